// File: rtl/fp_multiplier.sv
// IEEE binary32 multiplier, RNE rounding, flush-to-zero; operands captured at edge N, result valid after edge N+2.
// Fully pipelined, one pair per cycle, no backpressure; result holds its value between tokens.
module fp_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result
);

  // Stage 1: operand decode and special-case classification
  logic [7:0]        ea, eb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              nan_d, inf_d, zero_d, sign_d;
  logic signed [9:0] exp1_d;

  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign inf_d  = (a_inf | b_inf) & ~nan_d;
  assign zero_d = (a_zero | b_zero) & ~nan_d & ~inf_d;
  assign sign_d = a[31] ^ b[31];
  assign exp1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  logic              v1_q, sign1_q, nan1_q, inf1_q, zero1_q;
  logic signed [9:0] exp1_q;
  logic [23:0]       sig_a1_q, sig_b1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      sign1_q  <= 1'b0;
      nan1_q   <= 1'b0;
      inf1_q   <= 1'b0;
      zero1_q  <= 1'b0;
      exp1_q   <= '0;
      sig_a1_q <= '0;
      sig_b1_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        sign1_q  <= sign_d;
        nan1_q   <= nan_d;
        inf1_q   <= inf_d;
        zero1_q  <= zero_d;
        exp1_q   <= exp1_d;
        sig_a1_q <= {1'b1, a[22:0]};
        sig_b1_q <= {1'b1, b[22:0]};
      end
    end
  end

  // Stage 2: significand product; special flags ride alongside
  logic              v2_q, sign2_q, nan2_q, inf2_q, zero2_q;
  logic signed [9:0] exp2_q;
  logic [47:0]       prod2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      nan2_q  <= 1'b0;
      inf2_q  <= 1'b0;
      zero2_q <= 1'b0;
      exp2_q  <= '0;
      prod2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sign2_q <= sign1_q;
        nan2_q  <= nan1_q;
        inf2_q  <= inf1_q;
        zero2_q <= zero1_q;
        exp2_q  <= exp1_q;
        prod2_q <= sig_a1_q * sig_b1_q;
      end
    end
  end

  // Normalize, round to nearest even, then let specials override
  logic [23:0]       mant;
  logic              g_bit, r_bit, s_bit, round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_n, exp_f;
  logic [22:0]       frac_f;
  logic [31:0]       result_d;

  always_comb begin
    if (prod2_q[47]) begin
      mant  = prod2_q[47:24];
      g_bit = prod2_q[23];
      r_bit = prod2_q[22];
      s_bit = |prod2_q[21:0];
      exp_n = exp2_q + 10'sd1;
    end else begin
      mant  = prod2_q[46:23];
      g_bit = prod2_q[22];
      r_bit = prod2_q[21];
      s_bit = |prod2_q[20:0];
      exp_n = exp2_q;
    end
    round_up = g_bit & (r_bit | s_bit | mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    if (mant_r[24]) begin
      exp_f  = exp_n + 10'sd1;
      frac_f = mant_r[23:1];
    end else begin
      exp_f  = exp_n;
      frac_f = mant_r[22:0];
    end

    if (nan2_q)                 result_d = 32'h7FC0_0000;
    else if (inf2_q)            result_d = {sign2_q, 8'hFF, 23'd0};
    else if (zero2_q)           result_d = {sign2_q, 31'd0};
    else if (exp_f >= 10'sd255) result_d = {sign2_q, 8'hFF, 23'd0};
    else if (exp_f <= 10'sd0)   result_d = {sign2_q, 31'd0};
    else                        result_d = {sign2_q, exp_f[7:0], frac_f};
  end

  logic        out_valid_q;
  logic [31:0] result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= v2_q;
      if (v2_q) result_q <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Bench for fp_multiplier: directed vector table, gap and mid-flight reset sequences, then random
// traffic scored against a real-arithmetic reference model with a due-cycle queue.
module tb_fp_multiplier;

  logic        clk, rst, in_valid, out_valid;
  logic [31:0] a, b, result;

  fp_multiplier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic [31:0] drv_exp = '0;
  logic [31:0] last_res = '0;
  exp_t        sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
    end
  endtask

  // Reference: exact significand product in real arithmetic, scaled into [2^23, 2^24) and rounded RNE
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic [63:0] p;
    real         m, fl;
    int          k, fi, be;
    s      = x[31] ^ y[31];
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) return 32'h7FC0_0000;
    if (x_inf || y_inf) return {s, 8'hFF, 23'd0};
    if (x_zero || y_zero) return {s, 31'd0};
    p = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
    m = real'(p);
    k = 0;
    while (m >= 16777216.0) begin
      m = m / 2.0;
      k++;
    end
    fl = $floor(m);
    fi = int'(fl);
    if ((m - fl) > 0.5 || ((m - fl) == 0.5 && (fi % 2) == 1)) fi++;
    if (fi == 16777216) begin
      fi = 8388608;
      k++;
    end
    be = int'(x[30:23]) + int'(y[30:23]) + k - 150;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be <= 0) return {s, 31'd0};
    return {s, be[7:0], fi[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 11))
      0:       return {s, 8'h00, 23'($urandom)};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
      3:       return {s, 8'($urandom_range(100, 154)), 23'd8388607};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Scoreboard: log accepted pairs at each edge, check outputs 1 time unit later
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst && in_valid) sb_q.push_back('{cyc + 2, drv_exp});
      #1;
      if (rst) begin
        sb_q.delete();
        last_res = '0;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
      end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_valid_token", {31'd0, out_valid}, 32'd1);
        chk("result", result, e.val);
        last_res = e.val;
      end else begin
        chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
        chk("result_hold", result, last_res);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    drv_exp  = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'h3FC00000, 32'h40200000, 32'h40700000};
    vecs[1]  = '{32'hBFA00000, 32'h40800000, 32'hC0A00000};
    vecs[2]  = '{32'h3F400000, 32'h3F000000, 32'h3EC00000};
    vecs[3]  = '{32'hC0400000, 32'hC0000000, 32'h40C00000};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
    vecs[5]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000};
    vecs[6]  = '{32'hFF800000, 32'h40000000, 32'hFF800000};
    vecs[7]  = '{32'h80000000, 32'h40400000, 32'h80000000};
    vecs[8]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000};
    vecs[9]  = '{32'h00800000, 32'h3F000000, 32'h00000000};
    vecs[10] = '{32'h3F800001, 32'h3F800001, 32'h3F800002};

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed vectors back-to-back
    for (int i = 0; i < 11; i++) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].r);
    idle(4);

    // in_valid gap 1,0,1
    drive(1'b1, 32'h40400000, 32'h40400000, 32'h41100000);
    drive(1'b0, 32'h12345678, 32'h9ABCDEF0, 32'd0);
    drive(1'b1, 32'hBF800000, 32'h3E800000, 32'hBE800000);
    idle(4);

    // Reset while a pair is in flight, then a fresh pair after release
    drive(1'b1, 32'h40000000, 32'h40000000, 32'h40800000);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h40A00000, 32'h40000000, 32'h41200000);
    idle(4);

    // Random traffic with random bubbles
    for (int i = 0; i < 600; i++) begin
      logic [31:0] x, y;
      x = rnd_op();
      y = rnd_op();
      if ($urandom_range(0, 3) != 0) drive(1'b1, x, y, ref_mul(x, y));
      else drive(1'b0, x, y, 32'd0);
    end
    idle(5);

    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected results never appeared", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
